// File: rtl/rssi_loc_pkg.sv
// Shared types and constants for the RSSI trilateration engine.
package rssi_loc_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONV,
      S_SCAN,
      S_DONE
   } state_t;

   localparam int unsigned POW10_W = 14;
   localparam int unsigned E_MAX   = 4;
   localparam logic [4:0][POW10_W-1:0] POW10 = {14'd10000, 14'd1000, 14'd100, 14'd10, 14'd1};

   // d carries one guard bit over a coordinate so it can span the grid diagonal
   localparam int unsigned D_W_EXTRA  = 1;
   localparam int unsigned D2_W_EXTRA = 2;

   function automatic int unsigned d_width(input int unsigned cw);
      return cw + D_W_EXTRA;
   endfunction

   function automatic int unsigned d2_width(input int unsigned cw);
      return 2 * cw + D2_W_EXTRA;
   endfunction

endpackage

// File: rtl/rssi_to_dist2.sv
// Combinational RSSI (Q8.12 dBm) plus calibration value to squared-distance estimate.
module rssi_to_dist2
   import rssi_loc_pkg::*;
#(
   parameter int unsigned CW       = 8,
   parameter int unsigned RW       = 20,
   parameter int unsigned VW       = 20,
   parameter int unsigned RSSI_REF = 59
) (
   input  logic [RW-1:0]     rssi_i,
   input  logic [VW-1:0]     value_i,
   output logic [2*CW+1:0]   d2_o
);

   localparam int unsigned DW  = d_width(CW);
   localparam int unsigned D2W = d2_width(CW);
   localparam int unsigned AW  = RW + 4;
   localparam int unsigned PW  = VW + POW10_W;

   localparam logic signed [AW-1:0] REF_Q  = AW'(RSSI_REF << 12);
   localparam logic signed [AW-1:0] TEN    = AW'(10);
   localparam logic signed [AW-1:0] EMAX_S = AW'(E_MAX);
   localparam logic [PW-1:0]        D_SAT  = PW'((1 << DW) - 1);

   logic signed [AW-1:0] a;
   logic signed [AW-1:0] half;
   logic signed [AW-1:0] e_full;
   logic [2:0]           e;
   logic [PW-1:0]        prod;
   logic [PW-1:0]        d_full;
   logic [DW-1:0]        d;
   logic [D2W-1:0]       d2;

   always_comb begin
      a      = -$signed({{(AW-RW){rssi_i[RW-1]}}, rssi_i});
      half   = (a - REF_Q) >>> 1;
      // any negative quotient clamps to 0, so truncating division matches floor here
      e_full = (half / TEN) >>> 12;
      if (e_full[AW-1]) begin
         e = 3'd0;
      end else if (e_full > EMAX_S) begin
         e = 3'(E_MAX);
      end else begin
         e = e_full[2:0];
      end
      prod   = PW'(POW10[e]) * PW'(value_i);
      d_full = prod >> 12;
      d      = (d_full > D_SAT) ? DW'(D_SAT) : d_full[DW-1:0];
      d2     = D2W'(d) * D2W'(d);
   end

   assign d2_o = d2;

endmodule

// File: rtl/rssi_locator_n.sv
// RSSI trilateration engine: captures a job, converts each anchor, raster-scans the grid.
// Define BEST_FIT_EN to scan the full grid and report the minimum total-error point.
module rssi_locator_n
   import rssi_loc_pkg::*;
#(
   parameter int unsigned N_ANCH   = 3,
   parameter int unsigned CW       = 8,
   parameter int unsigned RW       = 20,
   parameter int unsigned VW       = 20,
   parameter int unsigned RSSI_REF = 59,
   parameter int unsigned TOL      = 75
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N_ANCH*CW-1:0] anc_x,
   input  logic [N_ANCH*CW-1:0] anc_y,
   input  logic [N_ANCH*RW-1:0] rssi,
   input  logic [N_ANCH*VW-1:0] value,
   output logic                 busy,
   output logic                 out_valid,
   output logic                 nomatch,
   output logic [CW-1:0]        xt,
   output logic [CW-1:0]        yt
);

   localparam int unsigned D2W = d2_width(CW);
   localparam int unsigned IW  = $clog2(N_ANCH);

   state_t                     state_q, state_d;
   logic [N_ANCH-1:0][CW-1:0]  ax_q, ay_q;
   logic [N_ANCH-1:0][RW-1:0]  rssi_q;
   logic [N_ANCH-1:0][VW-1:0]  val_q;
   logic [N_ANCH-1:0][D2W-1:0] d2_q;
   logic [IW-1:0]              idx_q, idx_d;
   logic [CW-1:0]              x_q, x_d, y_q, y_d;
   logic [CW-1:0]              xt_q, xt_d, yt_q, yt_d;
   logic                       nomatch_q, nomatch_d;
   logic                       transfer;
   logic                       last_pt;
   logic [D2W-1:0]             d2_new;
   logic [D2W-1:0]             err [N_ANCH];

   assign transfer = in_valid && (state_q == S_IDLE);
   assign last_pt  = (&x_q) && (&y_q);

   rssi_to_dist2 #(
      .CW       (CW),
      .RW       (RW),
      .VW       (VW),
      .RSSI_REF (RSSI_REF)
   ) u_conv (
      .rssi_i  (rssi_q[idx_q]),
      .value_i (val_q[idx_q]),
      .d2_o    (d2_new)
   );

   for (genvar i = 0; i < N_ANCH; i++) begin : g_lane
      logic [CW-1:0]  dx, dy;
      logic [D2W-1:0] dd;
      assign dx     = (x_q >= ax_q[i]) ? (x_q - ax_q[i]) : (ax_q[i] - x_q);
      assign dy     = (y_q >= ay_q[i]) ? (y_q - ay_q[i]) : (ay_q[i] - y_q);
      assign dd     = D2W'(dx) * D2W'(dx) + D2W'(dy) * D2W'(dy);
      assign err[i] = (dd >= d2_q[i]) ? (dd - d2_q[i]) : (d2_q[i] - dd);
   end

`ifdef BEST_FIT_EN
   localparam int unsigned EW = D2W + IW;

   logic [EW-1:0] err_sum, best_q, best_d;
   logic [CW-1:0] bx_q, bx_d, by_q, by_d;
   logic          better;

   always_comb begin
      err_sum = '0;
      for (int unsigned i = 0; i < N_ANCH; i++) begin
         err_sum = err_sum + EW'(err[i]);
      end
   end

   // strict compare keeps the earlier raster point on ties
   assign better = err_sum < best_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         best_q <= '1;
         bx_q   <= '0;
         by_q   <= '0;
      end else begin
         best_q <= best_d;
         bx_q   <= bx_d;
         by_q   <= by_d;
      end
   end
`else
   logic all_ok;

   always_comb begin
      all_ok = 1'b1;
      for (int unsigned i = 0; i < N_ANCH; i++) begin
         if (err[i] > D2W'(TOL)) begin
            all_ok = 1'b0;
         end
      end
   end
`endif

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      x_d       = x_q;
      y_d       = y_q;
      xt_d      = xt_q;
      yt_d      = yt_q;
      nomatch_d = nomatch_q;
`ifdef BEST_FIT_EN
      best_d    = best_q;
      bx_d      = bx_q;
      by_d      = by_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (transfer) begin
               state_d = S_CONV;
               idx_d   = '0;
            end
         end
         S_CONV: begin
            if (idx_q == IW'(N_ANCH - 1)) begin
               state_d = S_SCAN;
               x_d     = '0;
               y_d     = '0;
`ifdef BEST_FIT_EN
               best_d  = '1;
`endif
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_SCAN: begin
`ifdef BEST_FIT_EN
            if (better) begin
               best_d = err_sum;
               bx_d   = x_q;
               by_d   = y_q;
            end
            // the last point's verdict is folded in combinationally before leaving SCAN
            if (last_pt) begin
               state_d   = S_DONE;
               xt_d      = better ? x_q : bx_q;
               yt_d      = better ? y_q : by_q;
               nomatch_d = (better ? err_sum : best_q) > EW'(N_ANCH * TOL);
            end
`else
            if (all_ok) begin
               state_d   = S_DONE;
               xt_d      = x_q;
               yt_d      = y_q;
               nomatch_d = 1'b0;
            end else if (last_pt) begin
               state_d   = S_DONE;
               xt_d      = '1;
               yt_d      = '1;
               nomatch_d = 1'b1;
            end
`endif
            x_d = x_q + 1'b1;
            if (&x_q) begin
               y_d = y_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         x_q       <= '0;
         y_q       <= '0;
         xt_q      <= '0;
         yt_q      <= '0;
         nomatch_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         x_q       <= x_d;
         y_q       <= y_d;
         xt_q      <= xt_d;
         yt_q      <= yt_d;
         nomatch_q <= nomatch_d;
      end
   end

   always_ff @(posedge clk) begin
      if (transfer) begin
         ax_q   <= anc_x;
         ay_q   <= anc_y;
         rssi_q <= rssi;
         val_q  <= value;
      end
      if (state_q == S_CONV) begin
         d2_q[idx_q] <= d2_new;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q == S_CONV) || (state_q == S_SCAN);
   assign out_valid = (state_q == S_DONE);
   assign nomatch   = nomatch_q;
   assign xt        = xt_q;
   assign yt        = yt_q;

endmodule
